// File: rtl/bip_acc_uart_tx.sv
// bip_acc_uart_tx: captures the BIP accumulator on a rising halt edge and
// sends it out as UART 8N1 bytes, most-significant byte first, LSB first
// within each byte.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | line high, waiting for a halt rising edge
// S_START | start bit (tx=0) for CLKS_PER_BIT cycles
// S_DATA  | data bits 0..7 of the current byte, CLKS_PER_BIT cycles each
// S_STOP  | stop bit (tx=1); then next byte or back to idle with done
module bip_acc_uart_tx #(
  parameter int DATA_WIDTH   = 16,
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  halt,
  input  logic [DATA_WIDTH-1:0] acc,
  output logic                  tx,
  output logic                  busy,
  output logic                  done
);

  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int BIW    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [15:0]    BAUD_MAX  = 16'(CLKS_PER_BIT - 1);
  localparam logic [BIW-1:0] LAST_BYTE = BIW'(NBYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t                state_q, state_d;
  logic [15:0]           baud_q, baud_d;
  logic [2:0]            bit_idx_q, bit_idx_d;
  logic [BIW-1:0]        byte_idx_q, byte_idx_d;
  logic [DATA_WIDTH-1:0] shadow_q, shadow_d;
  logic                  halt_q;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  start_req;
  logic                  baud_wrap;
  logic [7:0]            cur_byte;

  assign start_req = halt & ~halt_q;
  assign baud_wrap = (baud_q == BAUD_MAX);
  // The byte on the wire always sits in the top 8 bits of the shadow.
  assign cur_byte  = shadow_q[DATA_WIDTH-1 -: 8];

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

  // State, counters, shadow and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      baud_q     <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      shadow_q   <= '0;
      halt_q     <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      shadow_q   <= shadow_d;
      halt_q     <= halt;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Next-state and next-output logic; tx/busy/done are computed one cycle
  // ahead so the pins come straight from flops.
  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    shadow_d   = shadow_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    if (state_q != S_IDLE) begin
      baud_d = baud_wrap ? 16'd0 : baud_q + 16'd1;
    end

    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        // done_q high means the frame just ended; an edge in that cycle is
        // treated as arriving while still busy and is dropped.
        if (start_req && !done_q) begin
          shadow_d   = acc;
          byte_idx_d = LAST_BYTE;
          bit_idx_d  = '0;
          state_d    = S_START;
          tx_d       = 1'b0;
          busy_d     = 1'b1;
        end
      end
      S_START: begin
        if (baud_wrap) begin
          state_d   = S_DATA;
          bit_idx_d = '0;
          tx_d      = cur_byte[0];
        end
      end
      S_DATA: begin
        if (baud_wrap) begin
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = cur_byte[bit_idx_q + 3'd1];
          end
        end
      end
      S_STOP: begin
        if (baud_wrap) begin
          if (byte_idx_q == '0) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            tx_d    = 1'b1;
          end else begin
            byte_idx_d = byte_idx_q - 1'b1;
            shadow_d   = shadow_q << 8;
            state_d    = S_START;
            tx_d       = 1'b0;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_bip_acc_uart_tx.sv
// Directed bench for bip_acc_uart_tx: a 16-bit instance at 4 clocks/bit and
// an 8-bit instance at 2 clocks/bit, sharing clock and reset.
module tb_bip_acc_uart_tx;

  logic        clk;
  logic        reset;
  logic        halt;
  logic [15:0] acc;
  logic        tx, busy, done;
  logic        halt8;
  logic [7:0]  acc8;
  logic        tx8, busy8, done8;

  int checks;
  int errors;

  logic tx_s   [0:255];
  logic done_s [0:255];
  logic busy_s [0:255];

  bip_acc_uart_tx #(.DATA_WIDTH(16), .CLKS_PER_BIT(4)) u_dut (
    .clk(clk), .reset(reset), .halt(halt), .acc(acc),
    .tx(tx), .busy(busy), .done(done)
  );

  bip_acc_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(2)) u_dut8 (
    .clk(clk), .reset(reset), .halt(halt8), .acc(acc8),
    .tx(tx8), .busy(busy8), .done(done8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected 16-bit line value t cycles after the tx fall, 4 clocks per bit.
  function automatic logic exp_bit16(input logic [15:0] d, input int t);
    int         f;
    int         p;
    logic [7:0] b;
    f = t / 40;
    p = (t % 40) / 4;
    b = (f == 0) ? d[15:8] : d[7:0];
    if (p == 0) return 1'b0;
    if (p == 9) return 1'b1;
    return b[p-1];
  endfunction

  function automatic logic [7:0] decode_byte(input int f);
    logic [7:0] b;
    for (int k = 0; k < 8; k++) b[k] = tx_s[f*40 + (k+1)*4 + 2];
    return b;
  endfunction

  function automatic int count_done(input int from, input int to);
    int c;
    c = 0;
    for (int t = from; t <= to; t++) if (done_s[t] === 1'b1) c++;
    return c;
  endfunction

  function automatic int first_done(input int n);
    for (int t = 0; t < n; t++) if (done_s[t] === 1'b1) return t;
    return -1;
  endfunction

  function automatic int count_tx_low(input int from, input int to);
    int c;
    c = 0;
    for (int t = from; t <= to; t++) if (tx_s[t] !== 1'b1) c++;
    return c;
  endfunction

  // Samples the 16-bit instance at n consecutive falling edges, starting with
  // the current one, applying optional acc/halt changes after sampling.
  task automatic capture16(input int n, input int acc_t, input logic [15:0] acc_v,
                           input int hlo_t, input int hhi_t);
    for (int t = 0; t < n; t++) begin
      if (t > 0) @(negedge clk);
      tx_s[t]   = tx;
      done_s[t] = done;
      busy_s[t] = busy;
      if (t == acc_t) acc = acc_v;
      if (t == hlo_t) halt = 1'b0;
      if (t == hhi_t) halt = 1'b1;
    end
  endtask

  task automatic start_frame(input string name);
    halt = 1'b1;
    @(negedge clk);
    checks++;
    if (tx !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s_start: tx=%b busy=%b required tx=0 busy=1", name, tx, busy);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    halt  = 1'b0;
    halt8 = 1'b0;
    acc   = 16'h0000;
    acc8  = 8'h00;
    repeat (3) @(negedge clk);
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || tx8 !== 1'b1 || busy8 !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: tx=%b busy=%b done=%b tx8=%b busy8=%b required 1 0 0 1 0",
               tx, busy, done, tx8, busy8);
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: tx=%b busy=%b required tx=1 busy=0", tx, busy);
    end
  endtask

  task automatic test_frame_a55a;
    int mism;
    acc = 16'hA55A;
    start_frame("a55a");
    capture16(90, -1, 16'h0, -1, -1);
    mism = 0;
    for (int t = 0; t < 80; t++) if (tx_s[t] !== exp_bit16(16'hA55A, t)) mism++;
    checks++;
    if (mism != 0) begin
      errors++;
      $display("FAIL a55a_line: %0d wrong samples required 0", mism);
    end
    checks++;
    if (decode_byte(0) !== 8'hA5 || decode_byte(1) !== 8'h5A) begin
      errors++;
      $display("FAIL a55a_bytes: got %h %h required a5 5a", decode_byte(0), decode_byte(1));
    end
    checks++;
    if (first_done(90) != 80 || count_done(0, 89) != 1) begin
      errors++;
      $display("FAIL a55a_done: first=%0d count=%0d required 80 1",
               first_done(90), count_done(0, 89));
    end
    checks++;
    if (busy_s[79] !== 1'b1 || busy_s[80] !== 1'b0) begin
      errors++;
      $display("FAIL a55a_busy: busy79=%b busy80=%b required 1 0", busy_s[79], busy_s[80]);
    end
    halt = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_shadow;
    acc = 16'h1234;
    start_frame("shadow");
    capture16(90, 10, 16'hFFFF, -1, -1);
    checks++;
    if (decode_byte(0) !== 8'h12 || decode_byte(1) !== 8'h34) begin
      errors++;
      $display("FAIL shadow_bytes: got %h %h required 12 34", decode_byte(0), decode_byte(1));
    end
    halt = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_hold_halt;
    acc = 16'h00FF;
    start_frame("hold");
    capture16(200, -1, 16'h0, -1, -1);
    checks++;
    if (count_done(0, 199) != 1 || first_done(200) != 80 || count_tx_low(80, 199) != 0) begin
      errors++;
      $display("FAIL hold_single_frame: done_count=%0d first=%0d low_after=%0d required 1 80 0",
               count_done(0, 199), first_done(200), count_tx_low(80, 199));
    end
    halt = 1'b0;
    @(negedge clk);
    start_frame("hold_again");
    capture16(90, -1, 16'h0, -1, -1);
    checks++;
    if (first_done(90) != 80 || decode_byte(1) !== 8'hFF) begin
      errors++;
      $display("FAIL hold_second_frame: first_done=%0d byte1=%h required 80 ff",
               first_done(90), decode_byte(1));
    end
    halt = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ignore_mid;
    acc = 16'h8001;
    start_frame("mid");
    capture16(150, -1, 16'h0, 5, 30);
    checks++;
    if (count_done(0, 149) != 1 || first_done(150) != 80 || count_tx_low(80, 149) != 0) begin
      errors++;
      $display("FAIL mid_edge_ignored: done_count=%0d first=%0d low_after=%0d required 1 80 0",
               count_done(0, 149), first_done(150), count_tx_low(80, 149));
    end
    halt = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_done_edge;
    acc = 16'h0F0F;
    start_frame("done_same");
    capture16(95, -1, 16'h0, 3, 80);
    checks++;
    if (count_done(0, 94) != 1 || count_tx_low(80, 94) != 0) begin
      errors++;
      $display("FAIL done_cycle_edge_ignored: done_count=%0d low_after=%0d required 1 0",
               count_done(0, 94), count_tx_low(80, 94));
    end
    halt = 1'b0;
    @(negedge clk);
    start_frame("done_next");
    capture16(84, -1, 16'h0, 3, 81);
    checks++;
    if (tx_s[80] !== 1'b1 || tx_s[81] !== 1'b1 || tx_s[82] !== 1'b0 || busy_s[82] !== 1'b1) begin
      errors++;
      $display("FAIL next_cycle_edge_accepted: tx80=%b tx81=%b tx82=%b busy82=%b required 1 1 0 1",
               tx_s[80], tx_s[81], tx_s[82], busy_s[82]);
    end
    halt = 1'b0;
    repeat (90) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    acc = 16'hFF00;
    start_frame("rst");
    capture16(50, -1, 16'h0, -1, -1);
    checks++;
    if (busy_s[49] !== 1'b1 || tx_s[49] !== 1'b0) begin
      errors++;
      $display("FAIL rst_pre: busy=%b tx=%b required 1 0", busy_s[49], tx_s[49]);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL rst_async: tx=%b busy=%b done=%b required 1 0 0", tx, busy, done);
    end
    halt = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    capture16(100, -1, 16'h0, -1, -1);
    checks++;
    if (count_tx_low(0, 99) != 0 || count_done(0, 99) != 0) begin
      errors++;
      $display("FAIL rst_after_release: low=%0d done_count=%0d required 0 0",
               count_tx_low(0, 99), count_done(0, 99));
    end
  endtask

  task automatic test_width8;
    int low_bad;
    int high_bad;
    int dfirst;
    int dcount;
    logic busy_at_done;
    low_bad = 0; high_bad = 0; dfirst = -1; dcount = 0; busy_at_done = 1'bx;
    acc8  = 8'h00;
    halt8 = 1'b1;
    @(negedge clk);
    for (int t = 0; t < 25; t++) begin
      if (t > 0) @(negedge clk);
      if (t < 18 && tx8 !== 1'b0) low_bad++;
      if (t >= 18 && tx8 !== 1'b1) high_bad++;
      if (done8 === 1'b1) begin
        dcount++;
        if (dfirst < 0) begin
          dfirst = t;
          busy_at_done = busy8;
        end
      end
    end
    checks++;
    if (low_bad != 0 || high_bad != 0) begin
      errors++;
      $display("FAIL w8_line: low_bad=%0d high_bad=%0d required 0 0", low_bad, high_bad);
    end
    checks++;
    if (dfirst != 20 || dcount != 1 || busy_at_done !== 1'b0) begin
      errors++;
      $display("FAIL w8_done: first=%0d count=%0d busy=%b required 20 1 0",
               dfirst, dcount, busy_at_done);
    end
    halt8 = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset;
    test_frame_a55a;
    test_shadow;
    test_hold_halt;
    test_ignore_mid;
    test_done_edge;
    test_reset_mid;
    test_width8;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
